delayed_rise: RTL and testbench

//   Rise-delay filter for a slow level trigger (e.g. a test-pulse or enable strobe).
//   - out rises only after trigger has stayed high for DELAY consecutive clocks.
//   - out falls one clock after trigger (post-sync) goes low.
//   - Rejects trigger pulses shorter than DELAY clocks; sits between an asynchronous

---
 rtl/delayed_rise.sv | 156 +++++++++++++++
 tb/tb_delayed_rise.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/delayed_rise.sv
// -----------------------------------------------------------------------------
// delayed_rise
//
// Purpose
//   Rise-delay filter for a slow level trigger such as a test-pulse or enable
//   strobe. The output rises only after the trigger has been sampled high for
//   DELAY consecutive clocks. It falls one clock after the sampled trigger goes
//   low. Any trigger pulse shorter than DELAY clocks is rejected.
//
//   The block sits between an asynchronous control input and synchronous
//   downstream logic.
//
// Configuration macro
//   DELAYED_RISE_SYNC_EN
//     defined   : trigger passes through a SYNC_STAGES-deep flop synchronizer,
//                 and the last stage is the sampled trigger.
//     undefined : trigger is registered once, with no metastability protection.
//                 Use this for callers that already drive trigger synchronously.
//
// Parameters
//   DELAY        consecutive high samples needed before out rises (1..2^CNT_W-1)
//   CNT_W        width of the run-length counter
//   SYNC_STAGES  synchronizer depth, used only with the macro (>= 2)
//
// Ports
//   clk      in   1  system clock; all logic on the rising edge
//   rst      in   1  synchronous, active-high reset; highest priority
//   trigger  in   1  level trigger; may be asynchronous to clk
//   out      out  1  registered delayed-rise output, glitch-free
//
// Latency from the trigger pin
//   rise : SYNC_STAGES+DELAY edges with the macro, 1+DELAY edges without
//   fall : SYNC_STAGES+1 edges with the macro, 2 edges without
// -----------------------------------------------------------------------------
module delayed_rise #(
    parameter int DELAY       = 16,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic trigger,
    output logic out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMING = 2'd1,
        HIGH   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(DELAY);

    logic w_trig_s;

    // -------------------------------------------------------------------------
    // Input stage
    // -------------------------------------------------------------------------
`ifdef DELAYED_RISE_SYNC_EN
    logic [SYNC_STAGES-1:0] r_sync;

    // The synchronizer is cleared on reset. As a result, a trigger that is
    // held high through reset earns no credit until it has propagated through
    // the stages again.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], trigger};
        end
    end

    assign w_trig_s = r_sync[SYNC_STAGES-1];
`else
    logic r_trig;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trig <= 1'b0;
        end else begin
            r_trig <= trigger;
        end
    end

    assign w_trig_s = r_trig;
`endif

    // -------------------------------------------------------------------------
    // Run-length FSM
    // out is 1 after edge n exactly when w_trig_s was 1 on edges
    // n-DELAY+1..n, with no reset inside that window.
    // -------------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_out;

    // NOTE: state, counter and output are all updated with non-blocking
    // assignments in one clocked block. Every branch therefore reads the
    // values from before the edge, and out is driven straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_out   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_trig_s) begin
                        r_count <= CNT_W'(1);
                        if (DELAY == 1) begin
                            r_state <= HIGH;
                            r_out   <= 1'b1;
                        end else begin
                            r_state <= ARMING;
                        end
                    end else begin
                        r_count <= '0;
                    end
                end

                ARMING: begin
                    if (w_trig_s) begin
                        r_count <= r_count + CNT_W'(1);
                        // The edge that completes the run also raises out.
                        if (r_count + CNT_W'(1) == DELAY_C) begin
                            r_state <= HIGH;
                            r_out   <= 1'b1;
                        end
                    end else begin
                        // A single low sample restarts the run.
                        r_state <= IDLE;
                        r_count <= '0;
                    end
                end

                HIGH: begin
                    // The counter holds at DELAY while high and never wraps.
                    if (!w_trig_s) begin
                        r_state <= IDLE;
                        r_count <= '0;
                        r_out   <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                    r_out   <= 1'b0;
                end
            endcase
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_delayed_rise.sv
// -----------------------------------------------------------------------------
// tb_delayed_rise
//
// Directed bench for delayed_rise. It uses two instances:
//   dut  : DELAY=16
//   dut1 : DELAY=1
//
// Inputs are driven on the falling edge, and outputs are sampled on the
// falling edge, so every sample reflects the state after the preceding
// rising edge.
// -----------------------------------------------------------------------------
module tb_delayed_rise;

`ifdef DELAYED_RISE_SYNC_EN
    localparam int IL = 2;   // edges from the trigger pin to the sampled trigger
`else
    localparam int IL = 1;
`endif
    localparam int DLY = 16;

    logic clk = 1'b0;
    logic rst;
    logic trigger;
    logic trigger1;
    logic out;
    logic out1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    delayed_rise #(.DELAY(DLY), .CNT_W(8), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .trigger (trigger),
        .out     (out)
    );

    delayed_rise #(.DELAY(1), .CNT_W(8), .SYNC_STAGES(2)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .trigger (trigger1),
        .out     (out1)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    int hi;
    int first;

    initial begin
        rst      = 1'b1;
        trigger  = 1'b0;
        trigger1 = 1'b0;
        tick(3);
        check("reset_out", {31'd0, out}, 32'd0);
        check("reset_count", {24'd0, dut.r_count}, 32'd0);
        rst = 1'b0;

        // 1. Reset in the middle of a count: no credit is kept from before reset.
        trigger = 1'b1;
        tick(10);
        check("midcount_out", {31'd0, out}, 32'd0);
        rst = 1'b1;
        tick(3);
        check("in_reset_out", {31'd0, out}, 32'd0);
        check("in_reset_count", {24'd0, dut.r_count}, 32'd0);
        rst = 1'b0;
        tick(IL + DLY - 1);
        check("post_reset_not_yet", {31'd0, out}, 32'd0);
        tick(1);
        check("post_reset_rise", {31'd0, out}, 32'd1);
        check("count_at_delay", {24'd0, dut.r_count}, 32'(DLY));
        tick(5);
        check("stay_high", {31'd0, out}, 32'd1);
        check("count_holds", {24'd0, dut.r_count}, 32'(DLY));

        // 2. Long high, then low: out falls IL+1 edges after the trigger drop.
        trigger = 1'b0;
        tick(IL);
        check("fall_not_yet", {31'd0, out}, 32'd1);
        tick(1);
        check("fall", {31'd0, out}, 32'd0);
        check("fall_count", {24'd0, dut.r_count}, 32'd0);

        // 3. Short pulses (two high, two low) must never assert out.
        hi = 0;
        for (int r = 0; r < 8; r++) begin
            trigger = 1'b1;
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                if (out) hi++;
            end
            trigger = 1'b0;
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                if (out) hi++;
            end
        end
        check("short_pulses_high_count", 32'(hi), 32'd0);
        tick(IL + 2);

        // 4a. Trigger high for exactly DELAY clocks: out is high for exactly one clock.
        trigger = 1'b1;
        hi      = 0;
        first   = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out) begin
                hi++;
                if (first == 0) first = i;
            end
            if (i == DLY) trigger = 1'b0;
        end
        check("exact_high_cycles", 32'(hi), 32'd1);
        check("exact_rise_edge", 32'(first), 32'(IL + DLY));

        // 4b. Trigger high for DELAY-1 clocks: out stays low.
        trigger = 1'b1;
        hi      = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out) hi++;
            if (i == DLY - 1) trigger = 1'b0;
        end
        check("short_by_one_high_cycles", 32'(hi), 32'd0);

        // 5. DELAY=1 instance, step up then step down.
        trigger1 = 1'b1;
        tick(IL);
        check("d1_rise_not_yet", {31'd0, out1}, 32'd0);
        tick(1);
        check("d1_rise", {31'd0, out1}, 32'd1);
        trigger1 = 1'b0;
        tick(IL);
        check("d1_fall_not_yet", {31'd0, out1}, 32'd1);
        tick(1);
        check("d1_fall", {31'd0, out1}, 32'd0);

        // 6. Reset while out=1 clears out on that edge, even with trigger still high.
        trigger  = 1'b1;
        trigger1 = 1'b1;
        tick(IL + DLY);
        check("pre_rst_out", {31'd0, out}, 32'd1);
        check("pre_rst_out1", {31'd0, out1}, 32'd1);
        rst = 1'b1;
        tick(1);
        check("rst_clears_out", {31'd0, out}, 32'd0);
        check("rst_clears_out1", {31'd0, out1}, 32'd0);
        rst = 1'b0;
        tick(IL + DLY - 1);
        check("rerise_not_yet", {31'd0, out}, 32'd0);
        tick(1);
        check("rerise", {31'd0, out}, 32'd1);

        trigger  = 1'b0;
        trigger1 = 1'b0;
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
